// File: rtl/tx_crc_append_pkg.sv
// Shared types and constants for the Tx CRC_A append stage.
package tx_crc_append_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } state_t;

    localparam int unsigned CRC_BITS = 16;
    localparam int unsigned CNT_W    = $clog2(CRC_BITS);

    // ISO/IEC 14443-3 type A: reflected CCITT polynomial, preset 0x6363, no final inversion
    localparam logic [CRC_BITS-1:0] CRC_A_INIT = 16'h6363;
    localparam logic [CRC_BITS-1:0] CRC_A_POLY = 16'h8408;

    function automatic logic [CRC_BITS-1:0] crc_a_step(input logic [CRC_BITS-1:0] crc,
                                                       input logic                din);
        logic [CRC_BITS-1:0] s;
        s = crc >> 1;
        if (crc[0] ^ din) begin
            s = s ^ CRC_A_POLY;
        end
        return s;
    endfunction

endpackage

// File: rtl/tx_crc_append_if.sv
// Bit-serial handshake bundle: upstream serialiser side (in_*) and encoder side (out_*).
interface tx_crc_append_if;

    logic in_valid;
    logic in_data;
    logic in_last;
    logic in_append;
    logic in_ready;
    logic out_valid;
    logic out_data;
    logic out_last;
    logic out_ready;

    modport master (
        output in_valid, in_data, in_last, in_append, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_append, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/tx_crc_append_crc_a.sv
// Bit-serial CRC_A accumulator; start (preset) takes priority over sample.
module crc_a
    import tx_crc_append_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                sample,
    input  logic                data,
    output logic [CRC_BITS-1:0] crc
);

    logic [CRC_BITS-1:0] crc_q;
    logic [CRC_BITS-1:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (start) begin
            crc_d = CRC_A_INIT;
        end else if (sample) begin
            crc_d = crc_a_step(crc_q, data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_A_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/tx_crc_append.sv
// Tx framing stage: passes frame bits through and optionally appends CRC_A, LSb first.
module tx_crc_append
    import tx_crc_append_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             abort,
    tx_crc_append_if.slave   bus,
    output logic             busy
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                append_q, append_d;
    logic                crc_start;
    logic                crc_sample;
    logic [CRC_BITS-1:0] crc;

    crc_a u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (crc_start),
        .sample (crc_sample),
        .data   (bus.in_data),
        .crc    (crc)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        append_d      = append_q;
        crc_start     = 1'b0;
        crc_sample    = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = 1'b0;
        bus.out_last  = 1'b0;

        case (state_q)
            // The bubble cycle here is what guarantees the CRC preset before the first data bit
            IDLE: begin
                crc_start = 1'b1;
                if (bus.in_valid) begin
                    append_d = bus.in_append;
                    state_d  = DATA;
                end
            end
            DATA: begin
                bus.out_valid = bus.in_valid;
                bus.out_data  = bus.in_data;
                bus.in_ready  = bus.out_ready;
                bus.out_last  = bus.in_last & ~append_q;
                crc_sample    = bus.in_valid & bus.out_ready;
                if (bus.in_valid && bus.out_ready && bus.in_last) begin
                    state_d = append_q ? CRC : IDLE;
                end
            end
            CRC: begin
                bus.out_valid = 1'b1;
                bus.out_data  = crc[cnt_q];
                bus.out_last  = (cnt_q == CNT_W'(CRC_BITS - 1));
                if (bus.out_ready) begin
                    if (cnt_q == CNT_W'(CRC_BITS - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            append_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            append_q <= append_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule
